// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries a WIDTH-bit field through DEPTH stages with valid, stall, flush and reset.
// Latency DEPTH edges in-to-out; stall holds every stage; flush/rst turn every stage into a bubble.
module id_ex_pipe_reg #(
    parameter int                 WIDTH       = 5,
    parameter int                 DEPTH       = 1,
    parameter logic [WIDTH-1:0]   BUBBLE_VAL  = '0,
    parameter bit                 IGNORE_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] probe,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [DEPTH-1:0] hit
);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("id_ex_pipe_reg: DEPTH must be in 1..8");
        end
    endgenerate

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Flush wins over stall; incoming data is loaded even when not valid.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = BUBBLE_VAL;
            end
            vld_d = '0;
        end else if (!stall) begin
            data_d[0] = in;
            vld_d[0]  = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= BUBBLE_VAL;
            end
            vld_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign out       = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];

    // Only combinational path in the block: probe -> hit.
    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = vld_q[k] && (data_q[k] == probe)
                     && !(IGNORE_ZERO && (data_q[k] == '0));
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: three configurations driven in lockstep and compared
// against a queue-based model of the pipeline contents.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic       vld;
        logic [4:0] dat;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [4:0] din = '0, probe = '0;

    logic [4:0] o1, o3, oz;
    logic       ov1, ov3, ovz;
    logic [0:0] h1;
    logic [2:0] h3, hz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.WIDTH(5), .DEPTH(1), .BUBBLE_VAL(5'd0), .IGNORE_ZERO(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in(din), .probe(probe), .out_valid(ov1), .out(o1), .hit(h1));
    id_ex_pipe_reg #(.WIDTH(5), .DEPTH(3), .BUBBLE_VAL(5'd0), .IGNORE_ZERO(1'b1)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in(din), .probe(probe), .out_valid(ov3), .out(o3), .hit(h3));
    id_ex_pipe_reg #(.WIDTH(5), .DEPTH(3), .BUBBLE_VAL(5'd8), .IGNORE_ZERO(1'b0)) u_dz (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in(din), .probe(probe), .out_valid(ovz), .out(oz), .hit(hz));

    logic [4:0] dout [3];
    logic       dov  [3];
    logic [7:0] dhit [3];
    assign dout[0] = o1;  assign dout[1] = o3;  assign dout[2] = oz;
    assign dov[0]  = ov1; assign dov[1]  = ov3; assign dov[2]  = ovz;
    assign dhit[0] = {7'b0, h1};
    assign dhit[1] = {5'b0, h3};
    assign dhit[2] = {5'b0, hz};

    // Reference: each pipe is a queue, newest item at index 0.
    int         mdep [3] = '{1, 3, 3};
    logic [4:0] mbub [3] = '{5'd0, 5'd0, 5'd8};
    bit         miz  [3] = '{1'b1, 1'b1, 1'b0};
    item_t      mq   [3][$];

    task automatic model_edge(input logic r, input logic f, input logic s,
                              input logic v, input logic [4:0] d);
        for (int c = 0; c < 3; c++) begin
            if (r || f) begin
                mq[c].delete();
                for (int k = 0; k < mdep[c]; k++) mq[c].push_back(item_t'{1'b0, mbub[c]});
            end else if (!s) begin
                mq[c].push_front(item_t'{v, d});
                void'(mq[c].pop_back());
            end
        end
    endtask

    function automatic logic [4:0] exp_out(input int c);
        item_t it;
        it = mq[c][mdep[c]-1];
        return it.dat;
    endfunction

    function automatic logic exp_ov(input int c);
        item_t it;
        it = mq[c][mdep[c]-1];
        return it.vld;
    endfunction

    function automatic logic [7:0] exp_hit(input int c, input logic [4:0] p);
        logic [7:0] h;
        item_t      it;
        h = '0;
        for (int k = 0; k < mdep[c]; k++) begin
            it = mq[c][k];
            if (it.vld && it.dat == p && !(miz[c] && it.dat == 5'd0)) h[k] = 1'b1;
        end
        return h;
    endfunction

    task automatic step(input logic r, input logic f, input logic s,
                        input logic v, input logic [4:0] d);
        rst = r; flush = f; stall = s; in_valid = v; din = d;
        @(posedge clk);
        model_edge(r, f, s, v, d);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] probes [2] = '{5'd0, 5'd8};
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd17);
        for (int i = 0; i < 2; i++) begin
            probe = probes[i];
            #1;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dout[c] !== mbub[c] || dov[c] !== 1'b0 || dhit[c] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset cfg%0d out=%0d vld=%0b hit=%b, want out=%0d vld=0 hit=0",
                             c, dout[c], dov[c], dhit[c], mbub[c]);
                end
            end
        end
    endtask

    task automatic test_depth1();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        checks++;
        if (o1 !== 5'd9 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL depth1_valid out=%0d vld=%0b, want 9/1", o1, ov1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        checks++;
        if (o1 !== 5'd3 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL depth1_invalid out=%0d vld=%0b, want 3/0", o1, ov1);
        end
    endtask

    task automatic test_shift();
        logic [4:0] seq [3] = '{5'd4, 5'd7, 5'd12};
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int e = 1; e <= 5; e++) begin
            if (e <= 3) step(1'b0, 1'b0, 1'b0, 1'b1, seq[e-1]);
            else        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
            checks++;
            if (e < 3) begin
                if (ov3 !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_early edge%0d vld=%0b, want 0", e, ov3);
                end
            end else if (ov3 !== 1'b1 || o3 !== seq[e-3]) begin
                errors++;
                $display("FAIL shift_out edge%0d out=%0d vld=%0b, want %0d/1", e, o3, ov3, seq[e-3]);
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'd31);
            probe = 5'd4;
            #1;
            checks++;
            if (ov3 !== 1'b0 || h3 !== 3'b010) begin
                errors++;
                $display("FAIL stall_hold%0d vld=%0b hit4=%b, want 0/010", i, ov3, h3);
            end
            probe = 5'd31;
            #1;
            checks++;
            if (h3 !== 3'b000) begin
                errors++;
                $display("FAIL stall_nocapture%0d hit31=%b, want 000", i, h3);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (o3 !== 5'd4 || ov3 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release out=%0d vld=%0b, want 4/1", o3, ov3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (o3 !== 5'd7 || ov3 !== 1'b1) begin
            errors++;
            $display("FAIL stall_second out=%0d vld=%0b, want 7/1", o3, ov3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (o3 !== 5'd0 || ov3 !== 1'b0) begin
            errors++;
            $display("FAIL stall_tail out=%0d vld=%0b, want 0/0", o3, ov3);
        end
    endtask

    task automatic test_flush_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd12);
        checks++;
        if (o3 !== 5'd4 || ov3 !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre out=%0d vld=%0b, want 4/1", o3, ov3);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd31);
        probe = 5'd8;
        #1;
        checks++;
        if (o3 !== 5'd0 || ov3 !== 1'b0 || h3 !== 3'b000) begin
            errors++;
            $display("FAIL flush_d3 out=%0d vld=%0b hit=%b, want 0/0/000", o3, ov3, h3);
        end
        checks++;
        if (oz !== 5'd8 || ovz !== 1'b0 || hz !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble_probe out=%0d vld=%0b hit=%b, want 8/0/000", oz, ovz, hz);
        end
    endtask

    task automatic test_hit();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        probe = 5'd8;
        #1;
        checks++;
        if (h3 !== 3'b110 || hz !== 3'b110 || h1 !== 1'b0) begin
            errors++;
            $display("FAIL hit_probe8 d3=%b dz=%b d1=%b, want 110/110/0", h3, hz, h1);
        end
        probe = 5'd0;
        #1;
        checks++;
        if (h3 !== 3'b000 || hz !== 3'b001 || h1 !== 1'b0) begin
            errors++;
            $display("FAIL hit_probe0 d3=%b dz=%b d1=%b, want 000/001/0", h3, hz, h1);
        end
    endtask

    task automatic test_rst_stall();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
        probe = 5'd2;
        #1;
        checks++;
        if (ov3 !== 1'b0 || o3 !== 5'd0 || h3 !== 3'b000 || oz !== 5'd8 || ovz !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall d3 out=%0d vld=%0b hit=%b dz out=%0d vld=%0b, want 0/0/000 8/0",
                     o3, ov3, h3, oz, ovz);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        checks++;
        if (o1 !== 5'd5 || ov1 !== 1'b1 || ov3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume1 d1=%0d/%0b d3vld=%0b, want 5/1 0", o1, ov1, ov3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ov3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume2 d3vld=%0b, want 0", ov3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (o3 !== 5'd5 || ov3 !== 1'b1) begin
            errors++;
            $display("FAIL rst_resume3 out=%0d vld=%0b, want 5/1", o3, ov3);
        end
    endtask

    task automatic test_random();
        logic       r, f, s, v;
        logic [4:0] d;
        item_t      it;
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step(r, f, s, v, d);
            if ($urandom_range(0, 1) == 0) begin
                it    = mq[1][$urandom_range(0, 2)];
                probe = it.dat;
            end else begin
                probe = 5'($urandom_range(0, 31));
            end
            #1;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dout[c] !== exp_out(c) || dov[c] !== exp_ov(c) || dhit[c] !== exp_hit(c, probe)) begin
                    errors++;
                    $display("FAIL random n%0d cfg%0d out=%0d vld=%0b hit=%b, want %0d/%0b/%b",
                             n, c, dout[c], dov[c], dhit[c], exp_out(c), exp_ov(c), exp_hit(c, probe));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_depth1();
        test_shift();
        test_stall();
        test_flush_stall();
        test_hit();
        test_rst_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised successor to the single-field ID/EX register-number latch.
- Carries a WIDTH-bit field (register number or control bundle) through DEPTH pipeline stages.
- Each stage holds a valid bit and supports stall (hold), flush (bubble insertion) and synchronous reset.
- Also provides a per-stage match vector against a probe register number, for use by the hazard/forwarding units.

Parameters:
- WIDTH, 5, width of the carried field (5 = MIPS register number).
- DEPTH, 1, number of register stages (legal range 1..8); DEPTH=1 is a single ID/EX latch.
- BUBBLE_VAL, 0, data value loaded into a stage on reset or flush.
- IGNORE_ZERO, 1, when 1 a data value of 0 never produces a match ($zero is not a real dependency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when 1, all stages hold their contents.
- flush  input  1  when 1, all stages are cleared to bubbles.
- in_valid  input  1  qualifies in_data.
- in  input  WIDTH  field entering stage 0.
- probe  input  WIDTH  register number to compare against the stage contents.
- out_valid  output  1  valid bit of the last stage (DEPTH-1).
- out  output  WIDTH  data of the last stage.
- hit  output  DEPTH  hit[k]=1 when stage k matches probe (combinational from registered state).

Behaviour:
- State: data[k] (WIDTH bits) and vld[k] for k=0..DEPTH-1. Both are registered and update only on the rising edge of clk.
- Priority at each edge: rst > flush > stall > shift.
- rst=1: every vld[k]<=0 and data[k]<=BUBBLE_VAL. Consequently out=BUBBLE_VAL, out_valid=0 and hit=0 from the first edge on which rst is sampled high. Before the first reset, values are undefined.
- flush=1 (rst=0): identical effect to reset on all stages. Flush overrides stall, and the value on in/in_valid in that cycle is discarded.
- stall=1 (rst=0, flush=0): all stages hold. in/in_valid are ignored (the upstream stage must also stall).
- Shift (none of the above): data[0]<=in and vld[0]<=in_valid; data[k]<=data[k-1] and vld[k]<=vld[k-1] for k>=1.
- Data is loaded even when in_valid=0. Consumers qualify it with out_valid.
- Latency: an item accepted at edge t appears on out/out_valid after edge t+DEPTH-1, i.e. DEPTH edges from in to out with no stalls. Each stalled cycle adds exactly one cycle.
- out=data[DEPTH-1] and out_valid=vld[DEPTH-1]. Both are direct register outputs with no combinational path from the inputs.
- hit[k] = vld[k] AND (data[k]==probe) AND NOT (IGNORE_ZERO AND data[k]==0). This is the only combinational path in the block (probe -> hit).
- Invalid stages never hit, including a bubble whose BUBBLE_VAL equals probe.
- Stalling for any number of cycles must not corrupt contents. A flush that arrives in the middle of a stall clears everything.
- rst asserted mid-stream clears everything in one edge. Shifting resumes on the first edge with rst=0.
- DEPTH outside 1..8 is a configuration error and must be flagged at elaboration (e.g. a generate-time error).

Test Plan:
1. WIDTH=5, DEPTH=1: rst for 1 edge, then in=5'd9, in_valid=1 -> after the next edge out=9, out_valid=1. The edge after that, with in_valid=0, in=3 -> out=3, out_valid=0.
2. DEPTH=3, no stall: drive 4, 7, 12 on consecutive edges with in_valid=1 -> out shows 4, 7, 12 on edges 3, 4, 5, and out_valid stays 0 before edge 3.
3. DEPTH=3, stall: load 4, 7, then hold stall=1 for 2 edges while in=31 -> contents are unchanged and 31 is never captured. After release, 4 emerges one edge later per stalled cycle.
4. DEPTH=3, flush with stall=1 simultaneously, pipe holding 4, 7, 12 -> after that edge out_valid=0, out=BUBBLE_VAL, hit=3'b000.
5. DEPTH=3, pipe holding 0, 8, 8 (all valid), probe=8 -> hit=3'b110. With probe=0 -> hit=3'b000 under IGNORE_ZERO=1, and hit=3'b001 under IGNORE_ZERO=0.
6. rst asserted during a stall with a full pipe -> all stages are cleared on that edge. Then deassert rst and shift in 5 -> out=5 after exactly DEPTH edges.
